// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Purpose  : Registered ALU with valid/ready handshakes on both sides.
//            Single-cycle ADD/SUB/logic/compare/shift ops, plus an optional
//            multi-cycle shift-add MUL. Produces carry/zero/overflow/negative
//            flags and an illegal-opcode error flag alongside each result.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   operand/opcode valid
//   in_ready   out  block can accept an operation this cycle
//   op         in   4-bit opcode (0 ADD .. 10 MUL, 11-15 illegal)
//   a, b       in   WIDTH-bit operands (shift amount = low log2(WIDTH) bits of b)
//   out_valid  out  result and flags valid
//   out_ready  in   consumer accepts the result
//   result     out  registered WIDTH-bit result
//   carry      out  adder carry-out (ADD/SUB only)
//   zero       out  result == 0
//   overflow   out  signed overflow (ADD/SUB) or nonzero high half (MUL)
//   negative   out  result MSB
//   err        out  illegal opcode flag for this result
// ============================================================================
module alu_seq #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             overflow,
    output logic             negative,
    output logic             err
);

    localparam int c_SHW = $clog2(WIDTH);

    localparam logic [3:0] c_OP_ADD  = 4'd0;
    localparam logic [3:0] c_OP_SUB  = 4'd1;
    localparam logic [3:0] c_OP_AND  = 4'd2;
    localparam logic [3:0] c_OP_OR   = 4'd3;
    localparam logic [3:0] c_OP_XOR  = 4'd4;
    localparam logic [3:0] c_OP_SLT  = 4'd5;
    localparam logic [3:0] c_OP_SLTU = 4'd6;
    localparam logic [3:0] c_OP_SLL  = 4'd7;
    localparam logic [3:0] c_OP_SRL  = 4'd8;
    localparam logic [3:0] c_OP_SRA  = 4'd9;
    localparam logic [3:0] c_OP_MUL  = 4'd10;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;

    logic             w_accept;
    logic             w_op_mul;
    logic             w_is_mul;
    logic             w_illegal;
    logic             w_cnt_zero;
    logic [WIDTH-1:0] w_mul_lo;
    logic             w_mul_ovf;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic             w_add_ovf;
    logic             w_sub_ovf;
    logic             w_slt;
    logic             w_sltu;
    logic [c_SHW-1:0] w_shamt;
    logic [WIDTH-1:0] w_sra;

    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_carry;
    logic             w_alu_ovf;

    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_zero;
    logic             r_overflow;
    logic             r_negative;
    logic             r_err;

    // ------------------------------------------------------------------------
    // Opcode decode
    // ------------------------------------------------------------------------
    assign w_accept  = in_valid && in_ready;
    assign w_op_mul  = (op == c_OP_MUL);
    // MUL falls into the illegal group when the multiplier is not built.
    assign w_illegal = (op > c_OP_MUL) || (w_op_mul && !w_is_mul);

    // ------------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------------
    assign w_sum  = {1'b0, a} + {1'b0, b};
    // Subtract as a + ~b + 1 so the carry-out reads as "no borrow" (a >= b).
    assign w_diff = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

    assign w_add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
    assign w_sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);

    // Signed less-than: the truncated difference sign is wrong exactly when
    // the subtraction overflowed, so correct it with the overflow bit.
    assign w_slt  = w_diff[WIDTH-1] ^ w_sub_ovf;
    assign w_sltu = ~w_diff[WIDTH];

    assign w_shamt = b[c_SHW-1:0];
    assign w_sra   = $unsigned($signed(a) >>> w_shamt);

    always_comb begin
        w_alu_res   = '0;
        w_alu_carry = 1'b0;
        w_alu_ovf   = 1'b0;
        case (op)
            c_OP_ADD: begin
                w_alu_res   = w_sum[WIDTH-1:0];
                w_alu_carry = w_sum[WIDTH];
                w_alu_ovf   = w_add_ovf;
            end
            c_OP_SUB: begin
                w_alu_res   = w_diff[WIDTH-1:0];
                w_alu_carry = w_diff[WIDTH];
                w_alu_ovf   = w_sub_ovf;
            end
            c_OP_AND:  w_alu_res = a & b;
            c_OP_OR:   w_alu_res = a | b;
            c_OP_XOR:  w_alu_res = a ^ b;
            c_OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, w_slt};
            c_OP_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, w_sltu};
            c_OP_SLL:  w_alu_res = a << w_shamt;
            c_OP_SRL:  w_alu_res = a >> w_shamt;
            c_OP_SRA:  w_alu_res = w_sra;
            default:   w_alu_res = '0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Shift-add multiplier
    // ------------------------------------------------------------------------
    generate
        if (MUL_EN) begin : g_mul
            localparam logic [c_SHW:0] c_CNT_INIT = (c_SHW+1)'(WIDTH);
            localparam logic [c_SHW:0] c_CNT_ONE  = (c_SHW+1)'(1);

            logic [2*WIDTH-1:0] r_mcand;
            logic [2*WIDTH-1:0] r_acc;
            logic [WIDTH-1:0]   r_mplier;
            logic [c_SHW:0]     r_cnt;

            // One partial product per cycle: add the shifted multiplicand when
            // the current multiplier LSB is set, then advance both operands.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_mcand  <= '0;
                    r_acc    <= '0;
                    r_mplier <= '0;
                    r_cnt    <= '0;
                end else if (w_accept && w_is_mul) begin
                    r_mcand  <= {{WIDTH{1'b0}}, a};
                    r_acc    <= '0;
                    r_mplier <= b;
                    r_cnt    <= c_CNT_INIT;
                end else if ((r_state == c_BUSY) && (r_cnt != '0)) begin
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt - c_CNT_ONE;
                end
            end

            assign w_is_mul   = w_op_mul;
            assign w_cnt_zero = (r_cnt == '0);
            assign w_mul_lo   = r_acc[WIDTH-1:0];
            assign w_mul_ovf  = |r_acc[2*WIDTH-1:WIDTH];
        end else begin : g_no_mul
            assign w_is_mul   = 1'b0;
            assign w_cnt_zero = 1'b1;
            assign w_mul_lo   = '0;
            assign w_mul_ovf  = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Control FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_is_mul ? c_BUSY : c_DONE;
                end
            end
            c_BUSY: begin
                // The cycle after the last step is spent latching the product.
                if (w_cnt_zero) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE: begin
                if (w_accept) begin
                    w_state_nxt = w_is_mul ? c_BUSY : c_DONE;
                end else if (out_ready) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Control FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            c_IDLE: in_ready = 1'b1;
            c_DONE: begin
                out_valid = 1'b1;
                // Draining the held result frees the slot in the same cycle.
                in_ready  = out_ready;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Result and flag registers
    // Only loaded on a single-cycle accept or on MUL completion, so they stay
    // bit-stable while DONE waits for out_ready.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result   <= '0;
            r_carry    <= 1'b0;
            r_zero     <= 1'b0;
            r_overflow <= 1'b0;
            r_negative <= 1'b0;
            r_err      <= 1'b0;
        end else if (w_accept && !w_is_mul) begin
            if (w_illegal) begin
                r_result   <= '0;
                r_carry    <= 1'b0;
                r_zero     <= 1'b1;
                r_overflow <= 1'b0;
                r_negative <= 1'b0;
                r_err      <= 1'b1;
            end else begin
                r_result   <= w_alu_res;
                r_carry    <= w_alu_carry;
                r_zero     <= (w_alu_res == '0);
                r_overflow <= w_alu_ovf;
                r_negative <= w_alu_res[WIDTH-1];
                r_err      <= 1'b0;
            end
        end else if ((r_state == c_BUSY) && w_cnt_zero) begin
            r_result   <= w_mul_lo;
            r_carry    <= 1'b0;
            r_zero     <= (w_mul_lo == '0);
            r_overflow <= w_mul_ovf;
            r_negative <= w_mul_lo[WIDTH-1];
            r_err      <= 1'b0;
        end
    end

    assign result   = r_result;
    assign carry    = r_carry;
    assign zero     = r_zero;
    assign overflow = r_overflow;
    assign negative = r_negative;
    assign err      = r_err;

endmodule
`default_nettype wire
